// File: rtl/plotfour_board_drawer_if.sv
// Pixel write bus from the board drawer into the VGA adapter.
interface plotfour_board_drawer_if;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;

  modport master (output x, y, colour, plot);
  modport slave  (input  x, y, colour, plot);
endinterface

// File: rtl/plotfour_board_drawer.sv
// Paints the snapshotted Plot Four board (6x7 squares) into the VGA frame
// buffer, one pixel per clock, raster order within each square.
module plotfour_board_drawer #(
    parameter int unsigned SQ = 16,
    parameter int unsigned X0 = 32,
    parameter int unsigned Y0 = 4
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            go,
    input  logic [41:0]                     blue,
    input  logic [41:0]                     red,
    input  logic [5:0]                      cursor,
    plotfour_board_drawer_if.master         vga,
    output logic                            busy,
    output logic                            done
);

    localparam int unsigned PW = (SQ > 2) ? $clog2(SQ) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(SQ - 1);
    localparam logic [7:0]    X_BASE = 8'(X0);
    localparam logic [7:0]    X_STEP = 8'(SQ);
    localparam logic [6:0]    Y_BASE = 7'(Y0);
    localparam logic [6:0]    Y_STEP = 7'(SQ);

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    state_t          state_q, state_d;
    logic [41:0]     blue_q, blue_d, red_q, red_d;
    logic [5:0]      cursor_q, cursor_d;
    logic [5:0]      sq_q, sq_d;
    logic [2:0]      row_q, row_d, col_q, col_d;
    logic [PW-1:0]   px_q, px_d, py_q, py_d;
    logic [7:0]      xbase_q, xbase_d;
    logic [6:0]      ybase_q, ybase_d;
    logic [7:0]      x_q, x_d;
    logic [6:0]      y_q, y_d;
    logic [2:0]      colour_q, colour_d;
    logic            plot_q, plot_d, busy_q, busy_d, done_q, done_d;
    logic            last_pix;
    logic [2:0]      pix_colour;

    assign vga.x      = x_q;
    assign vga.y      = y_q;
    assign vga.colour = colour_q;
    assign vga.plot   = plot_q;
    assign busy       = busy_q;
    assign done       = done_q;

    always_comb begin
        last_pix = (sq_q == 6'd41) && (py_q == P_LAST) && (px_q == P_LAST);
        if (px_q == '0 || py_q == '0)
            pix_colour = (sq_q == cursor_q) ? 3'b110 : 3'b111;
        else begin
            case ({blue_q[sq_q], red_q[sq_q]})
                2'b10:   pix_colour = 3'b001;
                2'b01:   pix_colour = 3'b100;
                2'b11:   pix_colour = 3'b101;
                default: pix_colour = 3'b000;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        blue_d   = blue_q;
        red_d    = red_q;
        cursor_d = cursor_q;
        sq_d     = sq_q;
        row_d    = row_q;
        col_d    = col_q;
        px_d     = px_q;
        py_d     = py_q;
        xbase_d  = xbase_q;
        ybase_d  = ybase_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (go) begin
                    state_d  = DRAW;
                    busy_d   = 1'b1;
                    blue_d   = blue;
                    red_d    = red;
                    cursor_d = cursor;
                    sq_d     = '0;
                    row_d    = '0;
                    col_d    = '0;
                    px_d     = '0;
                    py_d     = '0;
                    xbase_d  = X_BASE;
                    ybase_d  = Y_BASE;
                end
            end
            DRAW: begin
                busy_d   = 1'b1;
                plot_d   = 1'b1;
                x_d      = xbase_q + 8'(px_q);
                y_d      = ybase_q + 7'(py_q);
                colour_d = pix_colour;
                if (last_pix)
                    state_d = DONE;
                else if (px_q != P_LAST)
                    px_d = px_q + 1'b1;
                else begin
                    px_d = '0;
                    if (py_q != P_LAST)
                        py_d = py_q + 1'b1;
                    else begin
                        // Square change: step the pixel bases instead of multiplying.
                        py_d = '0;
                        sq_d = sq_q + 6'd1;
                        if (col_q == 3'd5) begin
                            col_d   = '0;
                            row_d   = row_q + 3'd1;
                            xbase_d = X_BASE;
                            ybase_d = ybase_q + Y_STEP;
                        end else begin
                            col_d   = col_q + 3'd1;
                            xbase_d = xbase_q + X_STEP;
                        end
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            blue_q   <= '0;
            red_q    <= '0;
            cursor_q <= '0;
            sq_q     <= '0;
            row_q    <= '0;
            col_q    <= '0;
            px_q     <= '0;
            py_q     <= '0;
            xbase_q  <= '0;
            ybase_q  <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            blue_q   <= blue_d;
            red_q    <= red_d;
            cursor_q <= cursor_d;
            sq_q     <= sq_d;
            row_q    <= row_d;
            col_q    <= col_d;
            px_q     <= px_d;
            py_q     <= py_d;
            xbase_q  <= xbase_d;
            ybase_q  <= ybase_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_plotfour_board_drawer.sv
// Scoreboard bench: expected pixels are queued at go, popped on every plot.
module tb_plotfour_board_drawer;

    localparam int N = 42 * 16 * 16;

    logic        clk = 1'b0;
    logic        resetn;
    logic        go;
    logic [41:0] blue, red;
    logic [5:0]  cursor;
    logic        busy, done;

    plotfour_board_drawer_if vga_if ();

    plotfour_board_drawer #(.SQ(16), .X0(32), .Y0(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .go     (go),
        .blue   (blue),
        .red    (red),
        .cursor (cursor),
        .vga    (vga_if),
        .busy   (busy),
        .done   (done)
    );

    always #10 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          plot_cnt = 0;
    int          done_cnt = 0;
    int          done_cyc_q[$];
    logic [17:0] sb[$];
    logic [17:0] got_pix, exp_pix, first_pix, last_pix;
    logic        first_pend = 1'b0;
    logic [2:0]  fb [0:159][0:119];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (vga_if.plot) begin
            got_pix = {vga_if.x, vga_if.y, vga_if.colour};
            exp_pix = (sb.size() > 0) ? sb.pop_front() : 18'h3ffff;
            check_eq("pixel", 32'(got_pix), 32'(exp_pix));
            if (vga_if.x < 8'd160 && vga_if.y < 7'd120) fb[vga_if.x][vga_if.y] = vga_if.colour;
            if (first_pend) begin
                first_pix  = got_pix;
                first_pend = 1'b0;
            end
            last_pix = got_pix;
            plot_cnt++;
        end
        if (done) begin
            done_cnt++;
            done_cyc_q.push_back(cyc);
        end
    end

    task automatic push_frame(input logic [41:0] b, input logic [41:0] r, input logic [5:0] c);
        int xx, yy;
        logic [2:0] col;
        for (int s = 0; s < 42; s++)
            for (int py = 0; py < 16; py++)
                for (int px = 0; px < 16; px++) begin
                    xx = 32 + (s % 6) * 16 + px;
                    yy = 4 + (s / 6) * 16 + py;
                    if (px == 0 || py == 0) col = (s == int'(c)) ? 3'b110 : 3'b111;
                    else if (b[s] && r[s])  col = 3'b101;
                    else if (b[s])          col = 3'b001;
                    else if (r[s])          col = 3'b100;
                    else                    col = 3'b000;
                    sb.push_back({8'(xx), 7'(yy), col});
                end
    endtask

    task automatic start_go(input logic [41:0] b, input logic [41:0] r, input logic [5:0] c);
        @(negedge clk);
        blue = b; red = r; cursor = c;
        plot_cnt = 0; done_cnt = 0; first_pend = 1'b1;
        push_frame(b, r, c);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        check_eq("busy_after_go", 32'(busy), 32'd1);
        check_eq("plot_after_go", 32'(vga_if.plot), 32'd0);
    endtask

    task automatic finish_frame();
        int lat;
        lat = -1;
        for (int i = 1; i <= N + 20; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
        check_eq("done_latency", 32'(lat), 32'(N + 1));
        @(negedge clk);
        check_eq("busy_after_done", 32'(busy), 32'd0);
        check_eq("done_width", 32'(done), 32'd0);
        check_eq("plot_count", 32'(plot_cnt), 32'(N));
        check_eq("done_count", 32'(done_cnt), 32'd1);
        check_eq("sb_left", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic [41:0] b, r;
        int cnt, seen, dc;

        resetn = 1'b0; go = 1'b0; blue = '0; red = '0; cursor = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_x", 32'(vga_if.x), 32'd0);
        check_eq("rst_y", 32'(vga_if.y), 32'd0);
        check_eq("rst_colour", 32'(vga_if.colour), 32'd0);
        check_eq("rst_plot", 32'(vga_if.plot), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);

        // go coincident with reset is ignored
        go = 1'b1;
        @(negedge clk);
        check_eq("go_during_reset", 32'(busy), 32'd0);
        go = 1'b0; resetn = 1'b1;
        @(negedge clk);

        start_go('0, '0, 6'd63);
        finish_frame();
        check_eq("first_pixel", 32'(first_pix), 32'({8'd32, 7'd4, 3'b111}));
        check_eq("last_xy", 32'(last_pix[17:3]), 32'({8'd127, 7'd115}));
        check_eq("blank_interior", 32'(fb[33][5]), 32'd0);

        b = '0; r = '0;
        b[0] = 1'b1; b[12] = 1'b1; r[12] = 1'b1; r[41] = 1'b1;
        start_go(b, r, 6'd7);
        finish_frame();
        check_eq("sq0_blue", 32'(fb[40][10]), 32'd1);
        check_eq("sq41_red", 32'(fb[120][110]), 32'd4);
        check_eq("sq7_cursor", 32'(fb[48][20]), 32'd6);
        check_eq("sq8_grid", 32'(fb[64][20]), 32'd7);
        check_eq("sq12_both", 32'(fb[34][38]), 32'd5);

        start_go('0, '0, 6'd63);
        b = '0; b[5] = 1'b1;
        blue = b;
        finish_frame();
        check_eq("snap_old", 32'(fb[117][9]), 32'd0);
        start_go(b, '0, 6'd63);
        finish_frame();
        check_eq("snap_new", 32'(fb[117][9]), 32'd1);

        start_go('0, '0, 6'd63);
        cnt = 0;
        for (int i = 0; i < N + 10; i++) begin
            if (vga_if.plot) cnt++;
            if (cnt == 5000) break;
            @(negedge clk);
        end
        check_eq("plots_before_rst", 32'(cnt), 32'd5000);
        resetn = 1'b0;
        dc = done_cnt;
        @(negedge clk);
        resetn = 1'b1;
        check_eq("midrst_plot", 32'(vga_if.plot), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_x", 32'(vga_if.x), 32'd0);
        check_eq("midrst_y", 32'(vga_if.y), 32'd0);
        sb.delete();
        repeat (20) @(negedge clk);
        check_eq("midrst_no_done", 32'(done_cnt), 32'(dc));
        check_eq("midrst_idle", 32'(busy), 32'd0);

        @(negedge clk);
        plot_cnt = 0; done_cnt = 0; first_pend = 1'b1;
        done_cyc_q.delete();
        blue = '0; red = '0; cursor = 6'd63;
        push_frame('0, '0, 6'd63);
        push_frame('0, '0, 6'd63);
        go = 1'b1;
        seen = 0;
        for (int i = 0; i < 2 * N + 50; i++) begin
            @(negedge clk);
            if (done) seen++;
            if (seen == 2) break;
        end
        go = 1'b0;
        check_eq("held_go_frames", 32'(seen), 32'd2);
        repeat (5) @(negedge clk);
        check_eq("held_go_done_cnt", 32'(done_cnt), 32'd2);
        check_eq("held_go_period", 32'(done_cyc_q[1] - done_cyc_q[0]), 32'(N + 2));
        check_eq("restart_first", 32'(first_pix), 32'({8'd32, 7'd4, 3'b111}));
        check_eq("held_go_plots", 32'(plot_cnt), 32'(2 * N));
        check_eq("held_go_sb_left", 32'(sb.size()), 32'd0);
        check_eq("held_go_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
